// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: NOP encoding, default PC width, fetch FSM states.
package riscv_pkg;

  localparam int          PC_W_DEFAULT = 16;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, hold freezes contents,
// otherwise load selects a real instruction or a bubble.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] pc_plus4_i,
  input  logic [31:0]     instr_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus4_q, pc_plus4_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;

  always_comb begin
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    // A bubble keeps PCD/PCPlus4D so downstream still sees the last real PC.
    if (flush_i || (!hold_i && !load_i)) begin
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (!hold_i) begin
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      instr_d    = instr_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= NOP;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: single-outstanding request FSM, one-entry hold buffer for
// responses arriving during a decode stall, and redirect handling.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            PCWriteD,
  input  logic            IF_IDWriteD,
  input  logic            PCSrcE,
  input  logic [PC_W-1:0] PCTargetE,
  output logic [PC_W-1:0] PCD,
  output logic [PC_W-1:0] PCPlus4D,
  output logic [31:0]     InstrD,
  output logic            ValidD
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            hold_vld_q, hold_vld_d;
  logic [PC_W-1:0] hold_pc_q, hold_pc_d;
  logic [31:0]     hold_instr_q, hold_instr_d;

  logic            ifid_load, from_buf;
  logic [PC_W-1:0] ifid_pc, ifid_pc_plus4;
  logic [31:0]     ifid_instr;

  assign imem_req_valid = !reset && (state_q == S_REQ) && PCWriteD && !hold_vld_q;
  assign imem_addr      = pc_q;
  assign ifid_pc        = from_buf ? hold_pc_q : pc_q;
  assign ifid_pc_plus4  = ifid_pc + PC_W'(4);
  assign ifid_instr     = from_buf ? hold_instr_q : imem_rsp_data;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_vld_d   = hold_vld_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    ifid_load    = 1'b0;
    from_buf     = 1'b0;
    if (PCSrcE) begin
      pc_d       = PCTargetE & ~PC_W'(3);
      hold_vld_d = 1'b0;
      // Go to S_DROP only if a response is still owed to us by memory.
      unique case (state_q)
        S_REQ:   state_d = (imem_req_valid && imem_req_ready) ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        S_DROP:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      if (hold_vld_q && IF_IDWriteD) begin
        ifid_load  = 1'b1;
        from_buf   = 1'b1;
        hold_vld_d = 1'b0;
        pc_d       = ifid_pc_plus4;
      end
      unique case (state_q)
        S_REQ: if (imem_req_valid && imem_req_ready) state_d = S_WAIT;
        S_WAIT: if (imem_rsp_valid) begin
          state_d = S_REQ;
          if (IF_IDWriteD) begin
            ifid_load = 1'b1;
            pc_d      = ifid_pc_plus4;
          end else begin
            hold_vld_d   = 1'b1;
            hold_pc_d    = pc_q;
            hold_instr_d = imem_rsp_data;
          end
        end
        S_DROP: if (imem_rsp_valid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      hold_vld_q   <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= NOP;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_vld_q   <= hold_vld_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  if_id_reg #(.PC_W(PC_W)) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ifid_load),
    .flush_i    (PCSrcE),
    .hold_i     (!IF_IDWriteD),
    .pc_i       (ifid_pc),
    .pc_plus4_i (ifid_pc_plus4),
    .instr_i    (ifid_instr),
    .pc_o       (PCD),
    .pc_plus4_o (PCPlus4D),
    .instr_o    (InstrD),
    .valid_o    (ValidD)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: instance a uses RESET_PC 0, instance b
// uses RESET_PC 16'hFFF8; both share the same stimulus.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready, rsp_valid, PCWriteD, IF_IDWriteD, PCSrcE;
  logic [31:0] rsp_data;
  logic [15:0] PCTargetE;

  logic        a_req, a_valid, b_req, b_valid;
  logic [15:0] a_addr, a_pcd, a_pc4, b_addr, b_pcd, b_pc4;
  logic [31:0] a_instr, b_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) u_a (
    .clk(clk), .reset(reset), .imem_req_valid(a_req), .imem_req_ready(ready),
    .imem_addr(a_addr), .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .PCWriteD(PCWriteD), .IF_IDWriteD(IF_IDWriteD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .PCD(a_pcd), .PCPlus4D(a_pc4), .InstrD(a_instr),
    .ValidD(a_valid)
  );

  instr_fetch_unit #(.PC_W(16), .RESET_PC(16'hFFF8)) u_b (
    .clk(clk), .reset(reset), .imem_req_valid(b_req), .imem_req_ready(ready),
    .imem_addr(b_addr), .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .PCWriteD(PCWriteD), .IF_IDWriteD(IF_IDWriteD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .PCD(b_pcd), .PCPlus4D(b_pc4), .InstrD(b_instr),
    .ValidD(b_valid)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    PCWriteD = 1'b1; IF_IDWriteD = 1'b1; PCSrcE = 1'b0; PCTargetE = 16'h0;
    ready = 1'b1; rsp_valid = 1'b0; rsp_data = 32'h0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; cyc(); cyc(); reset = 1'b0; #1;
  endtask

  // From S_REQ with the request accepted: one cycle to accept, one to respond.
  task automatic fetch_one(input logic [31:0] data);
    cyc();
    rsp_valid = 1'b1; rsp_data = data;
    cyc();
    rsp_valid = 1'b0; #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; cyc(); cyc();
    checks++; if ({a_req, a_pcd, a_pc4, a_instr, a_valid} !== {1'b0, 16'h0, 16'h0, NOP, 1'b0}) begin
      errors++; $display("FAIL reset_a got %h exp %h", {a_req, a_pcd, a_pc4, a_instr, a_valid}, {1'b0, 16'h0, 16'h0, NOP, 1'b0}); end
    checks++; if ({b_req, b_addr, b_valid} !== {1'b0, 16'hFFF8, 1'b0}) begin
      errors++; $display("FAIL reset_b got %h exp %h", {b_req, b_addr, b_valid}, {1'b0, 16'hFFF8, 1'b0}); end
  endtask

  task automatic test_sequential();
    reset = 1'b0; PCWriteD = 1'b0; #1;
    checks++; if (a_req !== 1'b0) begin errors++; $display("FAIL pcwrite_gate got %b exp 0", a_req); end
    cyc(); PCWriteD = 1'b1; #1;
    checks++; if ({a_req, a_addr} !== {1'b1, 16'h0000}) begin
      errors++; $display("FAIL s1_req0 got %h exp %h", {a_req, a_addr}, {1'b1, 16'h0000}); end
    cyc();
    checks++; if (a_req !== 1'b0) begin errors++; $display("FAIL s1_one_outstanding got %b exp 0", a_req); end
    rsp_valid = 1'b1; rsp_data = 32'hC0DE0000;
    cyc(); rsp_valid = 1'b0; #1;
    checks++; if ({a_valid, a_pcd, a_pc4, a_instr, a_req, a_addr} !== {1'b1, 16'h0000, 16'h0004, 32'hC0DE0000, 1'b1, 16'h0004}) begin
      errors++; $display("FAIL s1_pc0 got %h exp %h", {a_valid, a_pcd, a_pc4, a_instr, a_req, a_addr}, {1'b1, 16'h0000, 16'h0004, 32'hC0DE0000, 1'b1, 16'h0004}); end
    cyc();
    checks++; if ({a_valid, a_pcd, a_instr} !== {1'b0, 16'h0000, NOP}) begin
      errors++; $display("FAIL s1_bubble got %h exp %h", {a_valid, a_pcd, a_instr}, {1'b0, 16'h0000, NOP}); end
    rsp_valid = 1'b1; rsp_data = 32'hC0DE0004;
    cyc(); rsp_valid = 1'b0; #1;
    checks++; if ({a_valid, a_pcd, a_pc4, a_instr, a_addr} !== {1'b1, 16'h0004, 16'h0008, 32'hC0DE0004, 16'h0008}) begin
      errors++; $display("FAIL s1_pc4 got %h exp %h", {a_valid, a_pcd, a_pc4, a_instr, a_addr}, {1'b1, 16'h0004, 16'h0008, 32'hC0DE0004, 16'h0008}); end
    fetch_one(32'hC0DE0008);
    checks++; if ({a_valid, a_pcd, a_pc4, a_instr, a_addr} !== {1'b1, 16'h0008, 16'h000C, 32'hC0DE0008, 16'h000C}) begin
      errors++; $display("FAIL s1_pc8 got %h exp %h", {a_valid, a_pcd, a_pc4, a_instr, a_addr}, {1'b1, 16'h0008, 16'h000C, 32'hC0DE0008, 16'h000C}); end
  endtask

  task automatic test_stall();
    idle(); pulse_reset();
    fetch_one(32'hC0DE0000);
    fetch_one(32'hC0DE0004);
    IF_IDWriteD = 1'b0;
    cyc();
    checks++; if ({a_valid, a_pcd, a_instr} !== {1'b1, 16'h0004, 32'hC0DE0004}) begin
      errors++; $display("FAIL s2_hold1 got %h exp %h", {a_valid, a_pcd, a_instr}, {1'b1, 16'h0004, 32'hC0DE0004}); end
    rsp_valid = 1'b1; rsp_data = 32'hC0DE0008;
    cyc(); rsp_valid = 1'b0; #1;
    checks++; if ({a_valid, a_pcd, a_instr, a_req} !== {1'b1, 16'h0004, 32'hC0DE0004, 1'b0}) begin
      errors++; $display("FAIL s2_hold2 got %h exp %h", {a_valid, a_pcd, a_instr, a_req}, {1'b1, 16'h0004, 32'hC0DE0004, 1'b0}); end
    cyc();
    IF_IDWriteD = 1'b1; #1;
    checks++; if ({a_pcd, a_instr, a_req} !== {16'h0004, 32'hC0DE0004, 1'b0}) begin
      errors++; $display("FAIL s2_hold3 got %h exp %h", {a_pcd, a_instr, a_req}, {16'h0004, 32'hC0DE0004, 1'b0}); end
    cyc();
    checks++; if ({a_valid, a_pcd, a_pc4, a_instr, a_req, a_addr} !== {1'b1, 16'h0008, 16'h000C, 32'hC0DE0008, 1'b1, 16'h000C}) begin
      errors++; $display("FAIL s2_release got %h exp %h", {a_valid, a_pcd, a_pc4, a_instr, a_req, a_addr}, {1'b1, 16'h0008, 16'h000C, 32'hC0DE0008, 1'b1, 16'h000C}); end
  endtask

  task automatic test_redirect_wait();
    IF_IDWriteD = 1'b0;
    cyc();
    PCSrcE = 1'b1; PCTargetE = 16'h0040;
    cyc(); PCSrcE = 1'b0; IF_IDWriteD = 1'b1; #1;
    checks++; if ({a_valid, a_instr, a_pcd, a_req} !== {1'b0, NOP, 16'h0008, 1'b0}) begin
      errors++; $display("FAIL s3_flush got %h exp %h", {a_valid, a_instr, a_pcd, a_req}, {1'b0, NOP, 16'h0008, 1'b0}); end
    rsp_valid = 1'b1; rsp_data = 32'hC0DE000C;
    cyc(); rsp_valid = 1'b0; #1;
    checks++; if ({a_valid, a_req, a_addr} !== {1'b0, 1'b1, 16'h0040}) begin
      errors++; $display("FAIL s3_drop got %h exp %h", {a_valid, a_req, a_addr}, {1'b0, 1'b1, 16'h0040}); end
    fetch_one(32'hC0DE0040);
    checks++; if ({a_valid, a_pcd, a_pc4, a_instr} !== {1'b1, 16'h0040, 16'h0044, 32'hC0DE0040}) begin
      errors++; $display("FAIL s3_target got %h exp %h", {a_valid, a_pcd, a_pc4, a_instr}, {1'b1, 16'h0040, 16'h0044, 32'hC0DE0040}); end
  endtask

  task automatic test_redirect_same_cycle();
    cyc();
    PCSrcE = 1'b1; PCTargetE = 16'h0023; rsp_valid = 1'b1; rsp_data = 32'hC0DE0044;
    cyc(); PCSrcE = 1'b0; rsp_valid = 1'b0; #1;
    checks++; if ({a_valid, a_pcd, a_req, a_addr} !== {1'b0, 16'h0040, 1'b1, 16'h0020}) begin
      errors++; $display("FAIL s4_discard got %h exp %h", {a_valid, a_pcd, a_req, a_addr}, {1'b0, 16'h0040, 1'b1, 16'h0020}); end
    fetch_one(32'hC0DE0020);
    checks++; if ({a_valid, a_pcd, a_pc4, a_instr} !== {1'b1, 16'h0020, 16'h0024, 32'hC0DE0020}) begin
      errors++; $display("FAIL s4_target got %h exp %h", {a_valid, a_pcd, a_pc4, a_instr}, {1'b1, 16'h0020, 16'h0024, 32'hC0DE0020}); end
  endtask

  task automatic test_wrap();
    idle(); pulse_reset();
    checks++; if ({b_req, b_addr} !== {1'b1, 16'hFFF8}) begin
      errors++; $display("FAIL s5_first got %h exp %h", {b_req, b_addr}, {1'b1, 16'hFFF8}); end
    fetch_one(32'hC0DEFFF8);
    checks++; if ({b_valid, b_pcd, b_pc4, b_instr, b_addr} !== {1'b1, 16'hFFF8, 16'hFFFC, 32'hC0DEFFF8, 16'hFFFC}) begin
      errors++; $display("FAIL s5_fff8 got %h exp %h", {b_valid, b_pcd, b_pc4, b_instr, b_addr}, {1'b1, 16'hFFF8, 16'hFFFC, 32'hC0DEFFF8, 16'hFFFC}); end
    fetch_one(32'hC0DEFFFC);
    checks++; if ({b_valid, b_pcd, b_pc4, b_instr, b_addr} !== {1'b1, 16'hFFFC, 16'h0000, 32'hC0DEFFFC, 16'h0000}) begin
      errors++; $display("FAIL s5_fffc got %h exp %h", {b_valid, b_pcd, b_pc4, b_instr, b_addr}, {1'b1, 16'hFFFC, 16'h0000, 32'hC0DEFFFC, 16'h0000}); end
    fetch_one(32'hC0DE0000);
    checks++; if ({b_valid, b_pcd, b_pc4, b_addr} !== {1'b1, 16'h0000, 16'h0004, 16'h0004}) begin
      errors++; $display("FAIL s5_0000 got %h exp %h", {b_valid, b_pcd, b_pc4, b_addr}, {1'b1, 16'h0000, 16'h0004, 16'h0004}); end
  endtask

  task automatic test_reset_mid();
    cyc();
    checks++; if (a_req !== 1'b0) begin errors++; $display("FAIL s6_wait got %b exp 0", a_req); end
    reset = 1'b1; #1;
    checks++; if ({a_req, a_valid, a_pcd, a_pc4, a_instr, a_addr} !== {1'b0, 1'b0, 16'h0, 16'h0, NOP, 16'h0}) begin
      errors++; $display("FAIL s6_async got %h exp %h", {a_req, a_valid, a_pcd, a_pc4, a_instr, a_addr}, {1'b0, 1'b0, 16'h0, 16'h0, NOP, 16'h0}); end
    cyc();
    reset = 1'b0; ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hDEADBEEF; #1;
    checks++; if ({a_req, a_addr} !== {1'b1, 16'h0000}) begin
      errors++; $display("FAIL s6_first_req got %h exp %h", {a_req, a_addr}, {1'b1, 16'h0000}); end
    cyc(); rsp_valid = 1'b0; ready = 1'b1; #1;
    checks++; if ({a_valid, a_instr, a_req, a_addr} !== {1'b0, NOP, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL s6_stale_rsp got %h exp %h", {a_valid, a_instr, a_req, a_addr}, {1'b0, NOP, 1'b1, 16'h0000}); end
    fetch_one(32'hC0DE0000);
    checks++; if ({a_valid, a_pcd, a_pc4, a_instr} !== {1'b1, 16'h0000, 16'h0004, 32'hC0DE0000}) begin
      errors++; $display("FAIL s6_refetch got %h exp %h", {a_valid, a_pcd, a_pc4, a_instr}, {1'b1, 16'h0000, 16'h0004, 32'hC0DE0000}); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 16'h0000, giving the first fetch address.
REQ-002 The module SHALL have parameter PC_W, default 16, giving the program-counter width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port imem_req_valid, output, 1 bit: an instruction-memory request is pending.
REQ-006 The module SHALL have port imem_req_ready, input, 1 bit: memory accepts the request this cycle.
REQ-007 The module SHALL have port imem_addr, output, PC_W bits: byte address of the request.
REQ-008 The module SHALL have port imem_rsp_valid, input, 1 bit: response data is valid this cycle.
REQ-009 The module SHALL have port imem_rsp_data, input, 32 bits: the fetched instruction.
REQ-010 The module SHALL have port PCWriteD, input, 1 bit: hazard unit permits a new fetch request.
REQ-011 The module SHALL have port IF_IDWriteD, input, 1 bit: hazard unit permits an IF/ID update (0 means stall).
REQ-012 The module SHALL have port PCSrcE, input, 1 bit: taken branch or jump redirect from execute.
REQ-013 The module SHALL have port PCTargetE, input, PC_W bits: the redirect target.
REQ-014 The module SHALL have port PCD, output, PC_W bits: PC of the instruction held in IF/ID.
REQ-015 The module SHALL have port PCPlus4D, output, PC_W bits: PCD+4.
REQ-016 The module SHALL have port InstrD, output, 32 bits: the IF/ID instruction.
REQ-017 The module SHALL have port ValidD, output, 1 bit: InstrD is a real instruction, not a bubble.

Function
REQ-018 The FSM SHALL have exactly three states: S_REQ (issue request), S_WAIT (await response), and S_DROP (await a response that will be discarded); a one-entry hold buffer SHALL be separate from the FSM.
REQ-019 In S_REQ with PCWriteD=1, imem_req_valid SHALL be 1 and imem_addr SHALL equal the PC; on imem_req_ready=1 the FSM SHALL move to S_WAIT.
REQ-020 In S_REQ with PCWriteD=0, or while the hold buffer is full, imem_req_valid SHALL be 0.
REQ-021 In S_WAIT with imem_rsp_valid=1 and IF_IDWriteD=1, IF/ID SHALL load {PC, PC+4, imem_rsp_data, ValidD=1}, the PC SHALL advance by 4, and the FSM SHALL return to S_REQ; latency from response to ValidD is exactly 1 cycle.
REQ-022 In S_WAIT with imem_rsp_valid=1 and IF_IDWriteD=0, the response and its PC SHALL be captured in the hold buffer, IF/ID SHALL retain its value, and the FSM SHALL return to S_REQ.
REQ-023 While the hold buffer is full and IF_IDWriteD=1, IF/ID SHALL load from the buffer, the buffer SHALL clear, and the PC SHALL advance by 4.
REQ-024 When IF_IDWriteD=1 and no instruction is delivered that cycle, IF/ID SHALL load a bubble: InstrD=NOP (32'h00000013), ValidD=0, with PCD and PCPlus4D unchanged.
REQ-025 PCSrcE=1 SHALL take priority over every other event and SHALL:
- load PC with PCTargetE with bits [1:0] forced to 0;
- clear the hold buffer;
- load an IF/ID bubble regardless of IF_IDWriteD.
REQ-026 On PCSrcE=1, the next state SHALL be:
- S_DROP if in S_WAIT without a response, or if in S_REQ with the request accepted that same cycle;
- S_REQ in every other case, with any same-cycle response discarded.
REQ-027 In S_DROP, the first imem_rsp_valid=1 SHALL be discarded and the FSM SHALL move to S_REQ; a second PCSrcE in S_DROP SHALL update the PC only.
REQ-028 PC arithmetic SHALL be modulo 2^PC_W, so 16'hFFFC+4 = 16'h0000, and PCPlus4D SHALL wrap identically.
REQ-029 At most one memory request SHALL be outstanding at any time.

Reset
REQ-030 While reset=1, the outputs and state SHALL be:
- PC=RESET_PC;
- FSM in S_REQ;
- hold buffer empty;
- PCD=0, PCPlus4D=0, InstrD=NOP, ValidD=0;
- imem_req_valid=0.
REQ-031 Reset asserted mid-transaction SHALL abandon the outstanding request, and any response arriving after reset release while in S_REQ SHALL be ignored.

Structure
REQ-032 The package riscv_pkg SHALL hold the NOP constant, the PC_W default, and the fetch-state enumeration.
REQ-033 The IF/ID register SHALL be a sub-module named if_id_reg with load, flush, and hold controls.

Verification
REQ-034 Scenario 1: release reset with memory returning one cycle after acceptance. Required response: ValidD pulses carry PCD 0, 4, 8 with the matching InstrD, and imem_addr never skips.
REQ-035 Scenario 2: hold IF_IDWriteD=0 for 3 cycles while the response at PC 8 arrives. Required response: InstrD/PCD hold the PC 4 instruction, then PC 8 appears the cycle after IF_IDWriteD=1.
REQ-036 Scenario 3: assert PCSrcE with PCTargetE=16'h0040 while in S_WAIT. Required response: the late response is dropped, the next request address is 16'h0040, and ValidD=0 for the redirect cycle.
REQ-037 Scenario 4: assert PCSrcE and imem_rsp_valid in the same cycle with PCTargetE=16'h0023. Required response: the response is discarded and the next imem_addr is 16'h0020.
REQ-038 Scenario 5: set RESET_PC=16'hFFF8 and run sequential fetches. Required response: addresses are FFF8, FFFC, 0000, and PCPlus4D for FFFC is 0000.
REQ-039 Scenario 6: assert reset during S_WAIT, then release it. Required response: outputs hold reset values and the first request is to RESET_PC.
